// File: rtl/vga_timing_gen.sv
// Parametrised VGA/VESA sync generator: hsync/vsync, blank_n, scaled pixel coordinates and line/frame strobes.
// Define VGA_TIMING_PIPE_EN to add one pix_ce-qualified output register stage (all outputs lag by one pix_ce).
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int SCALE_X  = 1,
    parameter int SCALE_Y  = 1,
    parameter int CNT_W    = 11,
    parameter int POS_W    = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    output logic             h_sync,
    output logic             v_sync,
    output logic             blank_n,
    output logic [POS_W-1:0] pos_x,
    output logic [POS_W-1:0] pos_y,
    output logic             line_start,
    output logic             frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_BEG  = H_ACTIVE + H_FRONT;
    localparam int HS_END  = HS_BEG + H_SYNC;
    localparam int VS_BEG  = V_ACTIVE + V_FRONT;
    localparam int VS_END  = VS_BEG + V_SYNC;
    localparam int SXW     = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
    localparam int SYW     = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;

    // r_run stays low after reset so the first pix_ce lands on (0,0) rather than (1,0)
    logic             r_run;
    logic [CNT_W-1:0] r_h_cnt, r_v_cnt, w_h_nxt, w_v_nxt;
    logic [SXW-1:0]   r_x_sub, w_x_sub_nxt;
    logic [SYW-1:0]   r_y_sub, w_y_sub_nxt;
    logic [POS_W-1:0] r_x, r_y, w_x_nxt, w_y_nxt;
    logic             w_h_act, w_v_act, w_line;
    logic             w_hs, w_vs, w_bn, w_ls, w_fs;
    logic [POS_W-1:0] w_px, w_py;
    logic             r_hs, r_vs, r_bn, r_ls, r_fs;
    logic [POS_W-1:0] r_px, r_py;

    always_comb begin
        w_h_nxt = '0;
        w_v_nxt = '0;
        if (r_run) begin
            if (r_h_cnt == CNT_W'(H_TOTAL - 1)) begin
                w_h_nxt = '0;
                w_v_nxt = (r_v_cnt == CNT_W'(V_TOTAL - 1)) ? '0 : r_v_cnt + CNT_W'(1);
            end else begin
                w_h_nxt = r_h_cnt + CNT_W'(1);
                w_v_nxt = r_v_cnt;
            end
        end
    end

    always_comb begin
        w_h_act     = (w_h_nxt < CNT_W'(H_ACTIVE));
        w_v_act     = (w_v_nxt < CNT_W'(V_ACTIVE));
        w_line      = (w_h_nxt == '0);
        w_x_sub_nxt = '0;
        w_x_nxt     = '0;
        if (!w_line && w_h_act) begin
            if (r_x_sub == SXW'(SCALE_X - 1)) begin
                w_x_sub_nxt = '0;
                w_x_nxt     = r_x + POS_W'(1);
            end else begin
                w_x_sub_nxt = r_x_sub + SXW'(1);
                w_x_nxt     = r_x;
            end
        end
        // y scaler only moves at line boundaries
        w_y_sub_nxt = r_y_sub;
        w_y_nxt     = r_y;
        if (w_line) begin
            if (w_v_nxt == '0 || !w_v_act) begin
                w_y_sub_nxt = '0;
                w_y_nxt     = '0;
            end else if (r_y_sub == SYW'(SCALE_Y - 1)) begin
                w_y_sub_nxt = '0;
                w_y_nxt     = r_y + POS_W'(1);
            end else begin
                w_y_sub_nxt = r_y_sub + SYW'(1);
            end
        end
    end

    always_comb begin
        w_hs = (w_h_nxt >= CNT_W'(HS_BEG) && w_h_nxt < CNT_W'(HS_END)) ? H_POL : ~H_POL;
        w_vs = (w_v_nxt >= CNT_W'(VS_BEG) && w_v_nxt < CNT_W'(VS_END)) ? V_POL : ~V_POL;
        w_bn = w_h_act && w_v_act;
        w_px = w_bn ? w_x_nxt : '0;
        w_py = w_bn ? w_y_nxt : '0;
        w_ls = w_line;
        w_fs = w_line && (w_v_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
            r_x_sub <= '0;
            r_y_sub <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_hs    <= ~H_POL;
            r_vs    <= ~V_POL;
            r_bn    <= 1'b0;
            r_px    <= '0;
            r_py    <= '0;
            r_ls    <= 1'b0;
            r_fs    <= 1'b0;
        end else if (pix_ce) begin
            r_run   <= 1'b1;
            r_h_cnt <= w_h_nxt;
            r_v_cnt <= w_v_nxt;
            r_x_sub <= w_x_sub_nxt;
            r_y_sub <= w_y_sub_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_hs    <= w_hs;
            r_vs    <= w_vs;
            r_bn    <= w_bn;
            r_px    <= w_px;
            r_py    <= w_py;
            r_ls    <= w_ls;
            r_fs    <= w_fs;
        end
    end

`ifdef VGA_TIMING_PIPE_EN
    logic             r_p_hs, r_p_vs, r_p_bn, r_p_ls, r_p_fs;
    logic [POS_W-1:0] r_p_px, r_p_py;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_hs <= ~H_POL;
            r_p_vs <= ~V_POL;
            r_p_bn <= 1'b0;
            r_p_px <= '0;
            r_p_py <= '0;
            r_p_ls <= 1'b0;
            r_p_fs <= 1'b0;
        end else if (pix_ce) begin
            r_p_hs <= r_hs;
            r_p_vs <= r_vs;
            r_p_bn <= r_bn;
            r_p_px <= r_px;
            r_p_py <= r_py;
            r_p_ls <= r_ls;
            r_p_fs <= r_fs;
        end
    end

    assign h_sync      = r_p_hs;
    assign v_sync      = r_p_vs;
    assign blank_n     = r_p_bn;
    assign pos_x       = r_p_px;
    assign pos_y       = r_p_py;
    assign line_start  = r_p_ls;
    assign frame_start = r_p_fs;
`else
    assign h_sync      = r_hs;
    assign v_sync      = r_vs;
    assign blank_n     = r_bn;
    assign pos_x       = r_px;
    assign pos_y       = r_py;
    assign line_start  = r_ls;
    assign frame_start = r_fs;
`endif
endmodule
